// File: rtl/imem_loader_pkg.sv
// Shared types and defaults for the instruction-memory loader.
// Holds FSM states, error codes and the default memory size.
package imem_loader_pkg;

    localparam int MEM_SIZE_DEF = 1024;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_VERIFY = 3'd2,
        ST_DONE   = 3'd3,
        ST_ERR    = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        E_NONE  = 2'd0,
        E_ALIGN = 2'd1,
        E_RANGE = 2'd2,
        E_CSUM  = 2'd3
    } err_t;

endpackage

// File: rtl/imem_loader_if.sv
// Program-word stream between the source and the loader.
// Plain valid/ready handshake carrying one 32-bit word per beat.
interface imem_loader_if;

    logic        valid;
    logic [31:0] data;
    logic        ready;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/imem_loader.sv
// Streams program words into instruction RAM, then reads them back
// and compares XOR checksums before reporting done or error.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int MEM_SIZE = MEM_SIZE_DEF,
    parameter int CNT_W    = $clog2(MEM_SIZE/4)+1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [63:0]      base_addr,
    input  logic [CNT_W-1:0] word_count,
    imem_loader_if.slave     src,
    output logic             wr_en,
    output logic [63:0]      wr_addr,
    output logic [31:0]      wr_data,
    output logic [63:0]      rd_addr,
    input  logic [31:0]      rd_data,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [1:0]       err_code
);

    state_t           state;
    err_t             err;
    logic [63:0]      base;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] idx;
    logic [CNT_W-1:0] ridx;
    logic [31:0]      lsum;
    logic [31:0]      rsum;
    logic [31:0]      rsum_nx;
    logic [65:0]      end_addr;
    logic             can_start;
    logic             last_rd;

    // 66-bit end address so a base near 2^64 cannot wrap back into range
    assign end_addr  = {2'b00, base_addr}
                     + {{(64-CNT_W){1'b0}}, word_count, 2'b00};
    assign can_start = start && (state == ST_IDLE ||
                                 state == ST_DONE ||
                                 state == ST_ERR);
    assign src.ready = (state == ST_LOAD) && (idx < cnt);
    assign rd_addr   = (state == ST_VERIFY)
                     ? base + {{(62-CNT_W){1'b0}}, ridx, 2'b00}
                     : 64'd0;
    assign rsum_nx   = rsum ^ rd_data;
    assign last_rd   = (ridx == cnt - 1'b1);
    assign busy      = (state == ST_LOAD) || (state == ST_VERIFY);
    assign done      = (state == ST_DONE);
    assign error     = (state == ST_ERR);
    assign err_code  = err;

    // Sequencer: start check, stream-to-RAM writes, readback verify
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            err     <= E_NONE;
            base    <= '0;
            cnt     <= '0;
            idx     <= '0;
            ridx    <= '0;
            lsum    <= '0;
            rsum    <= '0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            wr_en <= 1'b0;
            if (can_start) begin
                err <= E_NONE;
                if (base_addr[1:0] != 2'b00) begin
                    state <= ST_ERR;
                    err   <= E_ALIGN;
                end else if (word_count == '0 ||
                             end_addr > 66'(MEM_SIZE)) begin
                    state <= ST_ERR;
                    err   <= E_RANGE;
                end else begin
                    state <= ST_LOAD;
                    base  <= base_addr;
                    cnt   <= word_count;
                    idx   <= '0;
                    ridx  <= '0;
                    lsum  <= '0;
                    rsum  <= '0;
                end
            end else begin
                case (state)
                    ST_LOAD: begin
                        if (src.valid && src.ready) begin
                            wr_en   <= 1'b1;
                            wr_addr <= base
                                + {{(62-CNT_W){1'b0}}, idx, 2'b00};
                            wr_data <= src.data;
                            lsum    <= lsum ^ src.data;
                            idx     <= idx + 1'b1;
                        end
                        // final write pulse is on the port this cycle
                        if (wr_en && idx == cnt)
                            state <= ST_VERIFY;
                    end
                    ST_VERIFY: begin
                        rsum <= rsum_nx;
                        ridx <= ridx + 1'b1;
                        if (last_rd) begin
                            // case-inequality also flags X/Z readback
                            if (rsum_nx !== lsum) begin
                                state <= ST_ERR;
                                err   <= E_CSUM;
                            end else begin
                                state <= ST_DONE;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader with a RAM model
// and a transaction-level reference of writes, status and latency.
module tb_imem_loader;
    import imem_loader_pkg::*;

    localparam int MEM_SIZE = MEM_SIZE_DEF;
    localparam int CNT_W    = $clog2(MEM_SIZE/4)+1;
    localparam int AW       = $clog2(MEM_SIZE);

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [63:0]      base_addr = '0;
    logic [CNT_W-1:0] word_count = '0;
    logic             wr_en;
    logic [63:0]      wr_addr;
    logic [31:0]      wr_data;
    logic [63:0]      rd_addr;
    logic [31:0]      rd_data;
    logic             busy;
    logic             done;
    logic             error;
    logic [1:0]       err_code;

    imem_loader_if src ();

    int n_chk  = 0;
    int n_pass = 0;

    logic [31:0] mem [MEM_SIZE/4];
    logic [63:0] corrupt_addr = '1;
    logic [63:0] wa_q [$];
    logic [31:0] wd_q [$];
    logic [31:0] words [$];
    bit          ready_seen;

    always #5 clk = ~clk;

    imem_loader #(
        .MEM_SIZE (MEM_SIZE),
        .CNT_W    (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .base_addr  (base_addr),
        .word_count (word_count),
        .src        (src),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .err_code   (err_code)
    );

    // RAM model with optional corruption of one address
    always @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr[AW-1:2]] <= (wr_addr == corrupt_addr)
                                  ? wr_data ^ 32'h10 : wr_data;
            wa_q.push_back(wr_addr);
            wd_q.push_back(wr_data);
        end
        if (src.ready)
            ready_seen = 1'b1;
    end

    assign rd_data = mem[rd_addr[AW-1:2]];

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic fill(input int n);
        words.delete();
        for (int i = 0; i < n; i++)
            words.push_back($urandom);
    endtask

    // mode: 0 valid held high, 1 toggling, 2 random gaps
    task automatic do_load(input logic [63:0] b, input int n,
                           input int mode, input int abort_at);
        logic [65:0] e;
        int          exp_code;
        int          cyc;
        int          sent;
        int          m;
        e = {2'b00, b} + 66'(n) * 66'd4;
        if (b[1:0] != 2'b00)
            exp_code = 1;
        else if (n == 0 || e > 66'(MEM_SIZE))
            exp_code = 2;
        else if ({2'b00, corrupt_addr} >= {2'b00, b} &&
                 {2'b00, corrupt_addr} < e)
            exp_code = 3;
        else
            exp_code = 0;
        wa_q.delete();
        wd_q.delete();
        ready_seen = 1'b0;
        @(negedge clk);
        start      = 1'b1;
        base_addr  = b;
        word_count = n[CNT_W-1:0];
        src.valid  = 1'b0;
        cyc  = 0;
        sent = 0;
        while (cyc < 4*n + 40) begin
            @(negedge clk);
            start = 1'b0;
            cyc++;
            if (cyc == 1)
                chk("busy_start", busy, exp_code == 0 || exp_code == 3);
            if (done || error)
                break;
            if (abort_at >= 0 && sent == abort_at) begin
                src.valid = 1'b0;
                rst_n = 1'b0;
                #1;
                chk("rst_wr_en", wr_en, 0);
                chk("rst_ready", src.ready, 0);
                chk("rst_busy", busy, 0);
                chk("rst_done", done, 0);
                chk("rst_error", error, 0);
                chk("rst_code", err_code, 0);
                chk("rst_wr_addr", wr_addr, 0);
                chk("rst_wr_data", wr_data, 0);
                chk("rst_rd_addr", rd_addr, 0);
                @(negedge clk);
                rst_n = 1'b1;
                repeat (3) @(negedge clk);
                chk("abort_no_more_wr", wa_q.size() <= abort_at, 1);
                chk("abort_idle_busy", busy, 0);
                return;
            end
            case (mode)
                0:       src.valid = 1'b1;
                1:       src.valid = cyc[0];
                default: src.valid = 1'($urandom_range(0, 1));
            endcase
            src.data = (sent < n) ? words[sent] : $urandom;
            #1;
            if (src.valid && src.ready)
                sent++;
        end
        src.valid = 1'b0;
        chk("finished", done | error, 1);
        chk("done", done, exp_code == 0);
        chk("error", error, exp_code != 0);
        chk("err_code", err_code, exp_code);
        chk("busy_end", busy, 0);
        if (exp_code == 1 || exp_code == 2) begin
            chk("ready_never", ready_seen, 0);
            chk("no_wr", wa_q.size(), 0);
            chk("err_latency", cyc, 1);
        end else begin
            chk("nwr", wa_q.size(), n);
            m = (wa_q.size() < n) ? wa_q.size() : n;
            for (int i = 0; i < m; i++) begin
                chk("wr_addr", wa_q[i], b + 64'(4*i));
                chk("wr_data", wd_q[i], words[i]);
            end
            if (mode == 0)
                chk("latency", cyc, 2*n + 2);
        end
    endtask

    initial begin
        int n;
        logic [63:0] b;
        src.valid = 1'b0;
        src.data  = '0;
        repeat (2) @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_ready", src.ready, 0);
        chk("reset_wr_en", wr_en, 0);
        chk("reset_code", err_code, 0);
        chk("reset_done", done, 0);
        chk("reset_error", error, 0);
        rst_n = 1'b1;

        words.delete();
        words.push_back(32'h91000421);
        words.push_back(32'h000000AA);
        words.push_back(32'h000000BB);
        words.push_back(32'h000000CC);
        do_load(64'd0, 4, 0, -1);

        do_load(64'd2, 4, 0, -1);
        do_load(64'd1020, 2, 0, -1);
        do_load(64'd0, 0, 0, -1);
        do_load(64'hFFFF_FFFF_FFFF_FFF8, 4, 0, -1);

        fill(2);
        do_load(64'd1016, 2, 0, -1);

        fill(3);
        do_load(64'd64, 3, 1, -1);

        corrupt_addr = 64'd4;
        fill(4);
        do_load(64'd0, 4, 0, -1);
        corrupt_addr = '1;

        fill(4);
        do_load(64'd0, 4, 0, 2);
        fill(4);
        do_load(64'd0, 4, 0, -1);

        for (int t = 0; t < 8; t++) begin
            n = $urandom_range(1, 16);
            b = 64'(4 * $urandom_range(0, MEM_SIZE/4 - n));
            fill(n);
            do_load(b, n, $urandom_range(0, 2), -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter MEM_SIZE, default 1024, instruction memory size in bytes (power of two, >4).
REQ-002 SHALL have parameter CNT_W, default $clog2(MEM_SIZE/4)+1, width of word_count.
REQ-003 Port clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 Port rst_n  in  1  asynchronous, active-low reset.
REQ-005 Port start  in  1  single-cycle load request, sampled only in IDLE, DONE or ERR.
REQ-006 Port base_addr  in  64  byte address of first word, sampled with start.
REQ-007 Port word_count  in  CNT_W  number of 32-bit words to load, sampled with start.
REQ-008 Port in_valid / in_data  in  1 / 32  program-word stream from the source.
REQ-009 Port in_ready  out  1  loader accepts in_data this cycle.
REQ-010 Port wr_en / wr_addr / wr_data  out  1 / 64 / 32  write port of the instruction RAM (RAM writes on clk edge when wr_en=1).
REQ-011 Port rd_addr  out  64  byte address driven to the RAM's combinational read port.
REQ-012 Port rd_data  in  32  combinational read data returned for rd_addr.
REQ-013 Port busy / done / error  out  1 each  status flags.
REQ-014 Port err_code  out  2  0 none, 1 misaligned base, 2 zero count or out of bounds, 3 readback checksum mismatch.

Function
REQ-015 FSM states SHALL be IDLE, LOAD, VERIFY, DONE, ERR; busy=1 exactly in LOAD and VERIFY.
REQ-016 On start in IDLE/DONE/ERR: base_addr[1:0]!=0 -> ERR code 1; else word_count==0 or base_addr+4*word_count>MEM_SIZE -> ERR code 2; else LOAD with word index, load checksum and readback checksum cleared.
REQ-017 Bounds arithmetic SHALL be done in 66 bits so base_addr near 2^64 cannot wrap into range.
REQ-018 start while busy SHALL be ignored.
REQ-019 in_ready SHALL equal 1 exactly while in LOAD and fewer than word_count words have been accepted.
REQ-020 Each handshake (in_valid & in_ready) SHALL produce, one cycle later, a single-cycle wr_en=1 with wr_addr=base+4*index and wr_data=in_data; index then increments.
REQ-021 Load checksum SHALL be XOR of all accepted in_data words.
REQ-022 FSM SHALL enter VERIFY the cycle after the final wr_en pulse; in_ready=0 from the final handshake onward.
REQ-023 In VERIFY, rd_addr SHALL step base, base+4, ... one word per cycle for word_count cycles, XOR-accumulating rd_data; rd_addr=0 outside VERIFY.
REQ-024 After the last readback word: checksums equal -> DONE; unequal, or any rd_data bit X/Z (!== compare) -> ERR code 3.
REQ-025 done SHALL be 1 only in DONE, error only in ERR; both hold until next accepted start, which clears them the following cycle.
REQ-026 Total latency for N words with in_valid held high: N cycles LOAD + 1 write cycle + N cycles VERIFY, done asserted on cycle 2N+2 after start.
REQ-027 in_valid gaps SHALL stall LOAD without losing data or producing spurious wr_en.

Reset
REQ-028 While rst_n=0: state IDLE, in_ready=0, wr_en=0, wr_addr=0, wr_data=0, rd_addr=0, busy=0, done=0, error=0, err_code=0, index and checksums 0.
REQ-029 Reset asserted mid-LOAD or mid-VERIFY SHALL abort immediately; a write already issued is not retracted, no further wr_en occurs.

Structure
REQ-030 Package imem_loader_pkg SHALL hold the state enum, err_code enum and default MEM_SIZE constant.
REQ-031 Single module; no sub-module required.

Verification
REQ-032 start, base=0, count=4, words 0x91000421,0xAA,0xBB,0xCC back-to-back -> four wr_en at addr 0,4,8,12, done on cycle 10, err_code 0.
REQ-033 start, base=0x2 -> error=1, err_code=1 next cycle, no wr_en, in_ready never 1.
REQ-034 start, base=1020, count=2 (end 1028>1024) -> err_code 2; also count=0 -> err_code 2.
REQ-035 count=3 with in_valid toggling every other cycle -> exactly three wr_en, correct data/addresses, done.
REQ-036 RAM model corrupts word at addr 4 on write -> ERR, err_code 3 after VERIFY.
REQ-037 rst_n low for one cycle after 2 of 4 words accepted -> all outputs reset values, IDLE; new start then completes normally.
